// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector. It raises a Mealy match flag and a
// registered copy, and keeps a saturating match counter.
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1010,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic [4:0]       fill
);

  localparam logic [4:0]       FILL_MAX = 5'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N-1:0]     r_pat;
  logic [N-2:0]     r_hist;
  logic [4:0]       r_fill;
  logic             r_yq;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_match;
  logic [N-1:0]     w_window;

  // A bit counts only when it is qualified and neither reset nor a pattern
  // load owns this edge.
  assign w_accept = en & ~reset & ~pat_load;
  assign w_window = {r_hist, x};
  assign w_match  = w_accept && (r_fill == FILL_MAX) && (w_window == r_pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
    end else if (pat_load) begin
      r_pat  <= pat_in;
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      if (w_match && (OVERLAP == 1'b0)) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[N-2:0];
        if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + 5'd1;
        end
      end
    end
  end

  // A clear wins over a coincident match; the match still shows on y/y_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_yq  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_yq <= w_match;
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_match && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign y         = w_match;
  assign y_q       = r_yq;
  assign match_cnt = r_cnt;
  assign fill      = r_fill;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (default, non-overlapping,
// 2-bit counter) share one stimulus stream and are checked against a bit-queue model.
module tb_seq_detect_param;

  localparam int N = 4;
  localparam logic [3:0] PAT0 = 4'b1010;

  logic       clk;
  logic       reset;
  logic       en;
  logic       x;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       y_w   [3];
  logic       yq_w  [3];
  logic [4:0] fill_w[3];
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  // reference model state per instance
  int m_q    [3][$];
  int m_pat  [3];
  int m_cnt  [3];
  int m_yq   [3];
  int m_ovl  [3] = '{1, 0, 1};
  int m_cmax [3] = '{255, 255, 3};

  seq_detect_param #(.N(4), .PATTERN(PAT0), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y_w[0]), .y_q(yq_w[0]),
    .match_cnt(cnt0), .fill(fill_w[0]));

  seq_detect_param #(.N(4), .PATTERN(PAT0), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y_w[1]), .y_q(yq_w[1]),
    .match_cnt(cnt1), .fill(fill_w[1]));

  seq_detect_param #(.N(4), .PATTERN(PAT0), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y_w[2]), .y_q(yq_w[2]),
    .match_cnt(cnt2), .fill(fill_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dut_cnt(input int d);
    case (d)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, d, $time, obs, exp);
    end
  endtask

  // Match = the last N-1 accepted bits followed by x spell the pattern.
  function automatic int model_y(input int d, input bit e, input bit b,
                                 input bit ld, input bit rst);
    int v;
    int sz;
    if (rst || ld || !e) return 0;
    sz = m_q[d].size();
    if (sz < N - 1) return 0;
    v = 0;
    for (int i = sz - (N - 1); i < sz; i++) v = v * 2 + m_q[d][i];
    v = v * 2 + int'(b);
    return (v == m_pat[d]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_q[d].delete();
      m_pat[d] = int'(PAT0);
      m_cnt[d] = 0;
      m_yq[d]  = 0;
    end
  endtask

  task automatic step(input bit e, input bit b, input bit ld, input logic [3:0] pin,
                      input bit clr, input bit rst);
    int ey[3];
    en = e; x = b; pat_load = ld; pat_in = pin; cnt_clr = clr; reset = rst;
    #3;
    for (int d = 0; d < 3; d++) begin
      ey[d] = model_y(d, e, b, ld, rst);
      chk("y", d, 32'(y_w[d]), 32'(ey[d]));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_yq[d] = ey[d];
        if (clr) m_cnt[d] = 0;
        else if (ey[d] == 1 && m_cnt[d] < m_cmax[d]) m_cnt[d]++;
        if (ld) begin
          m_pat[d] = int'(pin);
          m_q[d].delete();
        end else if (e) begin
          if (ey[d] == 1 && m_ovl[d] == 0) begin
            m_q[d].delete();
          end else begin
            m_q[d].push_back(int'(b));
            if (m_q[d].size() > N - 1) void'(m_q[d].pop_front());
          end
        end
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("y_q", d, 32'(yq_w[d]), 32'(m_yq[d]));
      chk("match_cnt", d, dut_cnt(d), 32'(m_cnt[d]));
      chk("fill", d, 32'(fill_w[d]), 32'(m_q[d].size()));
    end
  endtask

  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    en = 0; x = 0; pat_load = 0; pat_in = 0; cnt_clr = 0; reset = 1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);

    // basic stream on all three parameter sets
    bits(32'b101010, 6);
    chk("cnt_overlap", 0, 32'(cnt0), 32'd2);
    chk("cnt_no_overlap", 1, 32'(cnt1), 32'd1);
    chk("fill_no_overlap", 1, 32'(fill_w[1]), 32'd2);

    // gaps with en=0
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    bits(32'b10, 2);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("fill_gap", 0, 32'(fill_w[0]), 32'd2);
    bits(32'b10, 2);
    chk("cnt_gap", 0, 32'(cnt0), 32'd1);

    // reset mid-pattern
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    bits(32'b101, 3);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    bits(32'b0, 1);
    chk("fill_after_reset", 0, 32'(fill_w[0]), 32'd1);
    chk("cnt_after_reset", 0, 32'(cnt0), 32'd0);

    // runtime pattern load
    bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    bits(32'b0110, 4);
    chk("cnt_newpat", 0, 32'(cnt0), 32'd1);
    bits(32'b1010, 4);
    chk("cnt_oldpat_gone", 0, 32'(cnt0), 32'd1);

    // counter saturation, then clear with a coincident match
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    bits(32'b1010101010, 10);
    chk("cnt_sat", 2, 32'(cnt2), 32'd3);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    en = 1; x = 0; pat_load = 0; cnt_clr = 1; reset = 0;
    #3;
    chk("y_with_clr", 2, 32'(y_w[2]), 32'd1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("cnt_clr_wins", 2, 32'(cnt2), 32'd0);
    chk("yq_with_clr", 2, 32'(yq_w[2]), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 0) ? PAT0 : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter N, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1010: reset-time pattern; PATTERN[N-1] is the first bit received, PATTERN[0] the last.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed; 0 = bits consumed by a match are not reused.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  bit-valid qualifier; x is sampled only when en=1.
REQ-008 x  input  1  serial data bit.
REQ-009 pat_load  input  1  load pat_in into pattern register this edge.
REQ-010 pat_in  input  N  runtime pattern, same bit order as PATTERN.
REQ-011 cnt_clr  input  1  clear match counter this edge.
REQ-012 y  output  1  Mealy match flag, combinational from current state, en and x.
REQ-013 y_q  output  1  registered copy of y, valid one cycle after y.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.
REQ-015 fill  output  5  number of accepted bits currently held toward a match, 0..N-1.

Function
REQ-016 Block SHALL hold a pattern register (N bits), history shift register (N-1 bits) and fill counter as its state.
REQ-017 Accepted bit: en=1, reset=0, pat_load=0; only accepted bits SHALL change history/fill.
REQ-018 y SHALL be 1 iff the current bit is accepted, fill=N-1, and {history, x} equals the pattern register; otherwise 0.
REQ-019 On an accepted bit without match: history shifts in x; fill increments, saturating at N-1.
REQ-020 On a match with OVERLAP=1: history shifts in x; fill stays N-1.
REQ-021 On a match with OVERLAP=0: history and fill SHALL clear to 0 at that edge.
REQ-022 Cycles with en=0 SHALL leave history, fill, pattern and match_cnt unchanged; y=0.
REQ-023 y_q SHALL equal y of the previous cycle (latency 1); y_q=0 in the cycle after reset.
REQ-024 match_cnt SHALL increment by 1 on each edge where y=1, saturating at 2^CNT_W-1 (no wrap).
REQ-025 cnt_clr=1 SHALL set match_cnt to 0, taking priority over a simultaneous match (that match still drives y and y_q).
REQ-026 pat_load=1 SHALL load pat_in into pattern register and clear history and fill; x ignored that cycle, y=0.
REQ-027 Priority per edge: reset > pat_load > accepted bit.
REQ-028 Pattern change SHALL take effect for the first accepted bit after the load edge.

Reset
REQ-029 reset=1 at a rising edge SHALL set pattern register=PATTERN, history=0, fill=0, y_q=0, match_cnt=0.
REQ-030 While reset=1, y SHALL be 0 regardless of en/x.
REQ-031 Reset asserted mid-pattern SHALL discard the partial match; no match may complete using pre-reset bits.

Verification
REQ-032 Defaults; reset, then en=1, x=1,0,1,0,1,0 -> y=1 on bits 4 and 6 only; y_q=1 one cycle later each; match_cnt=2.
REQ-033 OVERLAP=0; same stream -> y=1 on bit 4 only; fill=0 after bit 4, 2 after bit 6; match_cnt=1.
REQ-034 Defaults; x=1,0 (en=1), two cycles en=0 with x=1, then x=1,0 (en=1) -> y=1 on final bit only; fill unchanged during gaps.
REQ-035 Defaults; x=1,0,1, reset one cycle, then x=0 -> y stays 0; fill=1 after the 0; match_cnt=0.
REQ-036 Defaults; x=1,0,1, pat_load with pat_in=4'b0110, then x=0,1,1,0 -> y=1 on last bit only; pattern 1010 no longer matches afterwards.
REQ-037 CNT_W=2, OVERLAP=1; stream 1,0,1,0,1,0,1,0,1,0 -> four matches, match_cnt=3 (saturated); cnt_clr pulse with concurrent match -> match_cnt=0, y=1.
